// File: rtl/mp_add_seq.sv
// mp_add_seq: multi-precision add sequencer.
// Operands arrive as WIDTH-bit limbs, least-significant first. One rca
// adds each limb and a registered carry links consecutive beats. Results
// leave on a registered valid/ready stream with one cycle of latency.
// The optional subtract mode is enabled by defining MP_ADD_SEQ_SUB_EN,
// which adds the in_sub port.

module rca #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c,
  output logic [WIDTH-1:0] s,
  output logic             co
);

  logic [WIDTH:0] chain_s;

  // Ripple the carry bit by bit from the LSB to the MSB.
  always_comb begin
    chain_s    = '0;
    s          = '0;
    chain_s[0] = c;
    for (int i = 0; i < WIDTH; i++) begin
      s[i]         = a[i] ^ b[i] ^ chain_s[i];
      chain_s[i+1] = (a[i] & b[i]) | (chain_s[i] & (a[i] ^ b[i]));
    end
    co = chain_s[WIDTH];
  end

endmodule

module mp_add_seq #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_first,
  input  logic             in_last,
  input  logic             cin,
`ifdef MP_ADD_SEQ_SUB_EN
  input  logic             in_sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_last,
  output logic             out_cout,
  output logic             out_ovf
);

  typedef enum logic [0:0] {
    ST_FIRST = 1'b0,
    ST_MID   = 1'b1
  } state_t;

  state_t           state_r;
  logic             carry_r;
  logic             first_s;
  logic             in_xfer_s;
  logic             out_xfer_s;
  logic [WIDTH-1:0] b_s;
  logic             c_s;
  logic [WIDTH-1:0] sum_s;
  logic             co_s;
  logic             ovf_s;
`ifdef MP_ADD_SEQ_SUB_EN
  logic             sub_r;
  logic             sub_s;
`endif

  // Handshake decode and adder operand selection for the current limb.
  always_comb begin
    in_ready   = !out_valid || out_ready;
    in_xfer_s  = in_valid && in_ready;
    out_xfer_s = out_valid && out_ready;
    // An in_first limb always restarts, even if an operation is open.
    first_s    = (state_r == ST_FIRST) || in_first;
`ifdef MP_ADD_SEQ_SUB_EN
    // Subtract mode is taken live on the first limb, latched afterwards.
    sub_s = first_s ? in_sub : sub_r;
    b_s   = sub_s ? ~in_b : in_b;
    if (first_s) begin
      c_s = sub_s ? 1'b1 : cin;
    end else begin
      c_s = carry_r;
    end
`else
    b_s = in_b;
    if (first_s) begin
      c_s = cin;
    end else begin
      c_s = carry_r;
    end
`endif
  end

  rca #(
    .WIDTH(WIDTH)
  ) u_rca (
    .a  (in_a),
    .b  (b_s),
    .c  (c_s),
    .s  (sum_s),
    .co (co_s)
  );

  // Signed overflow: same-sign operands produce a result of the other sign.
  always_comb begin
    ovf_s = (in_a[WIDTH-1] == b_s[WIDTH-1]) && (sum_s[WIDTH-1] != in_a[WIDTH-1]);
  end

  // Sequencer state, inter-limb carry and registered output stream.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_FIRST;
      carry_r   <= 1'b0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_last  <= 1'b0;
      out_cout  <= 1'b0;
      out_ovf   <= 1'b0;
`ifdef MP_ADD_SEQ_SUB_EN
      sub_r     <= 1'b0;
`endif
    end else if (in_xfer_s) begin
      out_valid <= 1'b1;
      out_sum   <= sum_s;
      out_last  <= in_last;
      carry_r   <= co_s;
      if (in_last) begin
        out_cout <= co_s;
        out_ovf  <= ovf_s;
        state_r  <= ST_FIRST;
      end else begin
        out_cout <= 1'b0;
        out_ovf  <= 1'b0;
        state_r  <= ST_MID;
      end
`ifdef MP_ADD_SEQ_SUB_EN
      sub_r <= sub_s;
`endif
    end else if (out_xfer_s) begin
      out_valid <= 1'b0;
    end else begin
      out_valid <= out_valid;
    end
  end

endmodule

// File: tb/tb_mp_add_seq.sv
// Directed self-checking bench for mp_add_seq at WIDTH=8.
// Define MP_ADD_SEQ_SUB_EN on both files to include the subtract case.

module tb_mp_add_seq;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_first;
  logic         in_last;
  logic         cin;
`ifdef MP_ADD_SEQ_SUB_EN
  logic         in_sub;
`endif
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_last;
  logic         out_cout;
  logic         out_ovf;

  int checks = 0;
  int errors = 0;

  mp_add_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_first  (in_first),
    .in_last   (in_last),
    .cin       (cin),
`ifdef MP_ADD_SEQ_SUB_EN
    .in_sub    (in_sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_last  (out_last),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present one limb for exactly one clock edge, then sample #1 after it.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic first, input logic last, input logic c);
    in_a     = a;
    in_b     = b;
    in_first = first;
    in_last  = last;
    cin      = c;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic expect_out(input string tag, input logic [W-1:0] sum,
                            input logic last, input logic cout, input logic ovf);
    check({tag, ".valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, ".sum"},   {24'd0, out_sum},   {24'd0, sum});
    check({tag, ".last"},  {31'd0, out_last},  {31'd0, last});
    check({tag, ".cout"},  {31'd0, out_cout},  {31'd0, cout});
    check({tag, ".ovf"},   {31'd0, out_ovf},   {31'd0, ovf});
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = 8'h00;
    in_b      = 8'h00;
    in_first  = 1'b0;
    in_last   = 1'b0;
    cin       = 1'b0;
    out_ready = 1'b1;
`ifdef MP_ADD_SEQ_SUB_EN
    in_sub    = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check("rst.valid", {31'd0, out_valid}, 32'd0);
    check("rst.sum",   {24'd0, out_sum},   32'd0);
    check("rst.last",  {31'd0, out_last},  32'd0);
    check("rst.cout",  {31'd0, out_cout},  32'd0);
    check("rst.ovf",   {31'd0, out_ovf},   32'd0);
    check("rst.ready", {31'd0, in_ready},  32'd1);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // 1. single limb 7F+01 -> 80 with signed overflow
    send(8'h7F, 8'h01, 1'b1, 1'b1, 1'b0);
    expect_out("t1", 8'h80, 1'b1, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    check("t1.drain", {31'd0, out_valid}, 32'd0);

    // 2. three-limb 0x00FFFF + 0x000001 = 0x010000
    send(8'hFF, 8'h01, 1'b1, 1'b0, 1'b0);
    expect_out("t2.l0", 8'h00, 1'b0, 1'b0, 1'b0);
    send(8'hFF, 8'h00, 1'b0, 1'b0, 1'b0);
    expect_out("t2.l1", 8'h00, 1'b0, 1'b0, 1'b0);
    send(8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
    expect_out("t2.l2", 8'h01, 1'b1, 1'b0, 1'b0);

    // 3. back-pressure: 0x01F012 + 0x012034 = 0x031046
    send(8'h12, 8'h34, 1'b1, 1'b0, 1'b0);
    expect_out("t3.l0", 8'h46, 1'b0, 1'b0, 1'b0);
    out_ready = 1'b0;
    in_a      = 8'hF0;
    in_b      = 8'h20;
    in_first  = 1'b0;
    in_last   = 1'b0;
    in_valid  = 1'b1;
    #1;
    check("t3.ready_low", {31'd0, in_ready}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("t3.hold_valid", {31'd0, out_valid}, 32'd1);
      check("t3.hold_sum",   {24'd0, out_sum},   32'h46);
      check("t3.hold_ready", {31'd0, in_ready},  32'd0);
    end
    out_ready = 1'b1;
    #1;
    check("t3.ready_high", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    expect_out("t3.l1", 8'h10, 1'b0, 1'b0, 1'b0);
    send(8'h01, 8'h01, 1'b0, 1'b1, 1'b0);
    expect_out("t3.l2", 8'h03, 1'b1, 1'b0, 1'b0);

    // 4. abort: open op leaves carry=1, new in_first limb must use cin
    send(8'hFF, 8'h01, 1'b1, 1'b0, 1'b0);
    expect_out("t4.l0", 8'h00, 1'b0, 1'b0, 1'b0);
    send(8'h01, 8'h01, 1'b1, 1'b1, 1'b0);
    expect_out("t4.abort", 8'h02, 1'b1, 1'b0, 1'b0);

    // 5. reset mid-operation drops output and returns to FIRST
    send(8'hFF, 8'h01, 1'b1, 1'b0, 1'b0);
    expect_out("t5.l0", 8'h00, 1'b0, 1'b0, 1'b0);
    out_ready = 1'b0;
    rst       = 1'b1;
    @(posedge clk);
    #1;
    rst       = 1'b0;
    out_ready = 1'b1;
    check("t5.rst_valid", {31'd0, out_valid}, 32'd0);
    check("t5.rst_sum",   {24'd0, out_sum},   32'd0);
    send(8'h10, 8'h20, 1'b0, 1'b1, 1'b0);
    expect_out("t5.after", 8'h30, 1'b1, 1'b0, 1'b0);

    // in_first=0 while in FIRST still takes cin
    send(8'h10, 8'h20, 1'b0, 1'b1, 1'b1);
    expect_out("t5.cin", 8'h31, 1'b1, 1'b0, 1'b0);

    // all-ones ripple: 0xFFFFFF + 0 + cin=1 -> 0x000000 carry out
    send(8'hFF, 8'h00, 1'b1, 1'b0, 1'b1);
    expect_out("rip.l0", 8'h00, 1'b0, 1'b0, 1'b0);
    send(8'hFF, 8'h00, 1'b0, 1'b0, 1'b0);
    expect_out("rip.l1", 8'h00, 1'b0, 1'b0, 1'b0);
    send(8'hFF, 8'h00, 1'b0, 1'b1, 1'b0);
    expect_out("rip.l2", 8'h00, 1'b1, 1'b1, 1'b0);

`ifdef MP_ADD_SEQ_SUB_EN
    // 6. 0x0100 - 0x0001 = 0x00FF; in_sub dropped on limb 2 must be ignored
    in_sub = 1'b1;
    send(8'h00, 8'h01, 1'b1, 1'b0, 1'b0);
    expect_out("t6.l0", 8'hFF, 1'b0, 1'b0, 1'b0);
    in_sub = 1'b0;
    send(8'h01, 8'h00, 1'b0, 1'b1, 1'b0);
    expect_out("t6.l1", 8'h00, 1'b1, 1'b1, 1'b0);
`endif

    @(posedge clk);
    #1;
    check("end.drain", {31'd0, out_valid}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
